tx_fsm: RTL and testbench
=========================

Name:
tx_fsm

Overview:
- 8-entry x 4-bit transmit FIFO with a stop-and-wait ARQ (automatic repeat request) transmit FSM, packaged as a TinyTapeout user tile.
- Host pushes nibbles, then requests transmissions one at a time. A 2-bit error-mode input emulates the channel result:
  - good → ACK;
  - corrupted → NACK;
  - retransmit → NACK, then ACK on the resend.
- An entry is popped only after it has been ACKed.

Parameters:
- DEPTH, 8, FIFO entries (power of two).
- DW, 4, data width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  tile enable; ignored, the design always runs.
- ui_in  input  8  [7]=wr_en, [6]=rd_en, [5:2]=data_in, [1:0]=err_mode.
- uo_out  output  8  [3:0]=data_out, [4]=ack, [5]=nack, [6]=full, [7]=empty.
- uio_in  input  8  unused.
- uio_out  output  8  [2:0]=fsm state, [6:3]=count (0..8), [7]=retry flag.
- uio_oe  output  8  constant 8'hFF.

Behaviour:
Reset (rst_n=0, asynchronous):
- Pointers and count = 0; state = IDLE.
- data_out = 0; ack = 0; nack = 0; retry = 0.
- Outputs read: empty = 1, full = 0.

FIFO write:
- On a clk edge with wr_en=1 and count<8: store data_in at wr_ptr; wr_ptr increments mod 8.
- Writes while full are dropped; no state changes.

Pop:
- Occurs only on an ACK cycle: rd_ptr increments mod 8.
- A write and a pop on the same edge leave count unchanged.

Flags:
- full = (count==8); empty = (count==0); both combinational from count.

FSM (encoding in uio_out[2:0]), one clock per state:
- IDLE (0):
  - If rd_en=1 and not empty: latch err_mode into mode_q, go to SEND.
  - rd_en while empty is ignored.
  - rd_en is sampled only in IDLE; pulses in any other state are ignored.
- SEND (1): data_out <= fifo[rd_ptr]; go to RESP.
- RESP (2), by mode_q:
  - 00: ack=1, pop, go to IDLE.
  - 01 or 11: nack=1, no pop (entry stays at head), go to IDLE.
  - 10: nack=1, retry=1, go to RETRY.
- RETRY (3): data_out <= fifo[rd_ptr] (resend); go to RESP2.
- RESP2 (4): ack=1, pop, retry=0, go to IDLE.
- Codes 5–7: unreachable; go to IDLE.

Output timing:
- ack and nack are registered, one-cycle pulses; they are never both 1.
- data_out holds its last sent value until the next SEND or RETRY.
- Latency from rd_en sample to response:
  - ack/nack appear 2 edges after the IDLE edge that samples rd_en;
  - the mode-10 ACK appears 4 edges after that edge.
- err_mode changes after launch have no effect (mode_q is latched).

Reset mid-transaction:
- Returns to IDLE immediately.
- FIFO contents are discarded (count=0).

Test Plan:
- Reset, then write 0,A,3,2 on 4 consecutive edges → count=4, empty=0, full=0.
- rd_en pulse, err_mode=00 → SEND then RESP; data_out=0, ack=1 for one cycle; count=3.
- rd_en pulse, err_mode=01 → data_out=A, nack=1 for one cycle; count stays 3. Next err_mode=00 read returns A again with ack.
- rd_en pulse, err_mode=10 → data_out=3, nack=1 with retry=1; two cycles later data_out=3 and ack=1; count decrements once. A rd_en pulse during this sequence is ignored.
- Write 9 values from empty → full=1 after the 8th; the 9th write is dropped. Eight 00-mode reads return the first 8 values in order, with pointer wrap-around; then empty=1. A further rd_en produces no ack/nack and state stays 0.
- Assert rst_n=0 while in RETRY → state=0 and count=0 immediately; ack=nack=0; data_out=0.

Source files
------------

// File: rtl/tx_fsm.sv
// tx_fsm: 8 x 4-bit transmit FIFO feeding a stop-and-wait ARQ transmitter.
// The host pushes nibbles and launches one transmission per rd_en pulse. The
// 2-bit err_mode emulates the channel result: 00 = ACK, 01/11 = NACK,
// 10 = NACK followed by an automatic resend that is ACKed. The head entry is
// popped only once it has been ACKed.
module tx_fsm #(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    RESP  = 3'd2,
    RETRY = 3'd3,
    RESP2 = 3'd4
  } state_t;

  // Input field decode.
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [1:0]    err_mode;

  assign wr_en    = ui_in[7];
  assign rd_en    = ui_in[6];
  assign data_in  = ui_in[5:2];
  assign err_mode = ui_in[1:0];

  // Tile enable and bidirectional inputs have no function in this design.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

  // Storage and state.
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          retry_q, retry_d;

  logic full;
  logic empty;
  logic wr_accept;
  logic pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en && !full;

  // FIFO storage write; contents need no reset because count gates validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Next-state and registered-output logic for the ARQ sequence.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    data_out_d = data_out_q;
    ack_d      = 1'b0;
    nack_d     = 1'b0;
    retry_d    = retry_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        // rd_en is only honoured here; the channel mode is frozen at launch.
        if (rd_en && !empty) begin
          mode_d  = err_mode;
          state_d = SEND;
        end
      end
      SEND: begin
        data_out_d = mem_q[rd_ptr_q];
        state_d    = RESP;
      end
      RESP: begin
        case (mode_q)
          2'b00: begin
            ack_d   = 1'b1;
            pop     = 1'b1;
            state_d = IDLE;
          end
          2'b10: begin
            nack_d  = 1'b1;
            retry_d = 1'b1;
            state_d = RETRY;
          end
          default: begin
            // Plain NACK: the entry stays at the head for a later attempt.
            nack_d  = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      RETRY: begin
        data_out_d = mem_q[rd_ptr_q];
        state_d    = RESP2;
      end
      RESP2: begin
        ack_d   = 1'b1;
        pop     = 1'b1;
        retry_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping; a simultaneous write and pop cancel.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with asynchronous reset that discards the FIFO contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      nack_q     <= 1'b0;
      retry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      nack_q     <= nack_d;
      retry_q    <= retry_d;
    end
  end

  assign uo_out  = {empty, full, nack_q, ack_q, data_out_q};
  assign uio_out = {retry_q, count_q, state_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tx_fsm.sv
// Directed testbench for tx_fsm: each task drives one scenario and checks
// hand-computed expectations inline. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
`timescale 1ns/1ps
module tb_tx_fsm;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       wr_en;
  logic       rd_en;
  logic [3:0] din;
  logic [1:0] mode;

  int checks;
  int errors;

  assign ui_in = {wr_en, rd_en, din, mode};

  tx_fsm dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed fields.
  wire [3:0] data_o  = uo_out[3:0];
  wire       ack_o   = uo_out[4];
  wire       nack_o  = uo_out[5];
  wire       full_o  = uo_out[6];
  wire       empty_o = uo_out[7];
  wire [2:0] state_o = uio_out[2:0];
  wire [3:0] count_o = uio_out[6:3];
  wire       retry_o = uio_out[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, count_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state_count: got state=%0d count=%0d, want 0/0", state_o, count_o);
    end
    checks++;
    if ({empty_o, full_o, ack_o, nack_o, retry_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got empty=%b full=%b ack=%b nack=%b retry=%b, want 1 0 0 0 0",
               empty_o, full_o, ack_o, nack_o, retry_o);
    end
    checks++;
    if (data_o !== 4'h0 || uio_oe !== 8'hFF) begin
      errors++;
      $display("FAIL reset_data_oe: got data=%h oe=%h, want 0/ff", data_o, uio_oe);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    $display("test_reset: state=%0d count=%0d empty=%b", state_o, count_o, empty_o);
  endtask

  task automatic test_write4();
    logic [3:0] vals [4];
    vals[0] = 4'h0; vals[1] = 4'hA; vals[2] = 4'h3; vals[3] = 4'h2;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = vals[i];
      step();
    end
    wr_en = 1'b0;
    checks++;
    if (count_o !== 4'd4 || empty_o !== 1'b0 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL write4: got count=%0d empty=%b full=%b, want 4 0 0", count_o, empty_o, full_o);
    end
    $display("test_write4: count=%0d", count_o);
  endtask

  // Launch a read and check the SEND -> RESP -> ACK/NACK sequence.
  task automatic test_read(input logic [1:0] m, input logic [3:0] exp_data,
                           input logic exp_ack, input logic [3:0] exp_count);
    rd_en = 1'b1;
    mode  = m;
    step();
    rd_en = 1'b0;
    mode  = ~m;  // changing err_mode after launch must have no effect
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL read_send_state: got %0d, want 1", state_o);
    end
    step();
    checks++;
    if (state_o !== 3'd2 || data_o !== exp_data) begin
      errors++;
      $display("FAIL read_resp_data: got state=%0d data=%h, want 2/%h", state_o, data_o, exp_data);
    end
    step();
    checks++;
    if (ack_o !== exp_ack || nack_o !== !exp_ack || count_o !== exp_count || state_o !== 3'd0) begin
      errors++;
      $display("FAIL read_response: got ack=%b nack=%b count=%0d state=%0d, want %b %b %0d 0",
               ack_o, nack_o, count_o, state_o, exp_ack, !exp_ack, exp_count);
    end
    mode = 2'b00;
    step();
    checks++;
    if (ack_o !== 1'b0 || nack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse_end: got ack=%b nack=%b, want 0 0", ack_o, nack_o);
    end
    $display("test_read mode=%b: data=%h count=%0d", m, exp_data, count_o);
  endtask

  task automatic test_ack_nack();
    test_read(2'b00, 4'h0, 1'b1, 4'd3);
    test_read(2'b01, 4'hA, 1'b0, 4'd3);
    test_read(2'b11, 4'hA, 1'b0, 4'd3);
    test_read(2'b00, 4'hA, 1'b1, 4'd2);
  endtask

  task automatic test_retry();
    rd_en = 1'b1;
    mode  = 2'b10;
    step();
    rd_en = 1'b0;
    mode  = 2'b00;
    step();
    checks++;
    if (data_o !== 4'h3 || state_o !== 3'd2) begin
      errors++;
      $display("FAIL retry_send: got data=%h state=%0d, want 3/2", data_o, state_o);
    end
    step();
    checks++;
    if (nack_o !== 1'b1 || ack_o !== 1'b0 || retry_o !== 1'b1 || state_o !== 3'd3 || count_o !== 4'd2) begin
      errors++;
      $display("FAIL retry_nack: got nack=%b ack=%b retry=%b state=%0d count=%0d, want 1 0 1 3 2",
               nack_o, ack_o, retry_o, state_o, count_o);
    end
    rd_en = 1'b1;  // must be ignored outside IDLE
    step();
    rd_en = 1'b0;
    checks++;
    if (state_o !== 3'd4 || nack_o !== 1'b0 || data_o !== 4'h3 || retry_o !== 1'b1) begin
      errors++;
      $display("FAIL retry_resend: got state=%0d nack=%b data=%h retry=%b, want 4 0 3 1",
               state_o, nack_o, data_o, retry_o);
    end
    step();
    checks++;
    if (ack_o !== 1'b1 || retry_o !== 1'b0 || state_o !== 3'd0 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL retry_ack: got ack=%b retry=%b state=%0d count=%0d, want 1 0 0 1",
               ack_o, retry_o, state_o, count_o);
    end
    step();
    step();
    checks++;
    if (state_o !== 3'd0 || count_o !== 4'd1 || ack_o !== 1'b0 || nack_o !== 1'b0) begin
      errors++;
      $display("FAIL retry_ignored_rd: got state=%0d count=%0d ack=%b nack=%b, want 0 1 0 0",
               state_o, count_o, ack_o, nack_o);
    end
    $display("test_retry: count=%0d", count_o);
    test_read(2'b00, 4'h2, 1'b1, 4'd0);
  endtask

  task automatic test_fill_wrap();
    wr_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      din = 4'(i);
      step();
      if (i == 8) begin
        checks++;
        if (full_o !== 1'b1 || count_o !== 4'd8) begin
          errors++;
          $display("FAIL fill_full: got full=%b count=%0d, want 1 8", full_o, count_o);
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (count_o !== 4'd8 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop9: got count=%0d full=%b, want 8 1", count_o, full_o);
    end
    $display("test_fill_wrap: filled count=%0d", count_o);
    for (int i = 1; i <= 8; i++) begin
      test_read(2'b00, 4'(i), 1'b1, 4'(8 - i));
    end
    checks++;
    if (empty_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b, want 1", empty_o);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL empty_rd_state: got %0d, want 0", state_o);
    end
    step();
    step();
    checks++;
    if (ack_o !== 1'b0 || nack_o !== 1'b0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL empty_rd_resp: got ack=%b nack=%b state=%0d, want 0 0 0", ack_o, nack_o, state_o);
    end
    $display("test_fill_wrap: drained empty=%b", empty_o);
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1;
    din = 4'h5;
    step();
    din = 4'h6;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    mode  = 2'b10;
    step();
    rd_en = 1'b0;
    step();
    step();
    checks++;
    if (state_o !== 3'd3 || nack_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: got state=%0d nack=%b, want 3 1", state_o, nack_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || count_o !== 4'd0 || ack_o !== 1'b0 || nack_o !== 1'b0 ||
        data_o !== 4'h0 || retry_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst: got state=%0d count=%0d ack=%b nack=%b data=%h retry=%b empty=%b, want 0 0 0 0 0 0 1",
               state_o, count_o, ack_o, nack_o, data_o, retry_o, empty_o);
    end
    step();
    rst_n = 1'b1;
    step();
    $display("test_reset_mid: state=%0d count=%0d", state_o, count_o);
    wr_en = 1'b1;
    din = 4'h7;
    step();
    wr_en = 1'b0;
    test_read(2'b00, 4'h7, 1'b1, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    ena    = 1'b1;
    uio_in = 8'h00;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = 4'h0;
    mode   = 2'b00;
    test_reset();
    test_write4();
    test_ack_nack();
    test_retry();
    test_fill_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
